lsu_dmem_ctrl: RTL and testbench

//  Load/store unit between the execute stage and the byte-array data memory.

---
 rtl/lsu_dmem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the execute stage and a word-addressed view of the
// byte-array data memory. One request in flight at a time. Sub-word stores are
// performed as read-modify-write. Illegal requests answer with an error and
// never reach memory.
module lsu_dmem_ctrl #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [2:0]         i_req_funct3,
    input  logic [NB_ADDR-1:0] i_req_addr,
    input  logic [NB_DATA-1:0] i_req_wdata,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_DATA-1:0] o_rsp_rdata,
    output logic               o_rsp_error,
    output logic [NB_ADDR-1:0] o_dmem_address,
    output logic               o_dmem_wr_enable,
    output logic [NB_DATA-1:0] o_dmem_wr_data,
    input  logic [NB_DATA-1:0] i_dmem_rd_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t               state_reg, state_next;
    logic                 we_reg;
    logic [2:0]           funct3_reg;
    logic [NB_ADDR-1:0]   addr_reg;
    logic [NB_DATA-1:0]   wdata_reg;
    logic [NB_DATA-1:0]   word_reg;
    logic [NB_DATA-1:0]   rdata_reg;
    logic                 error_reg;

    logic                 accept;
    logic [2:0]           req_size;
    logic [NB_ADDR:0]     req_end;
    logic                 funct3_legal;
    logic                 misaligned;
    logic                 out_of_range;
    logic                 req_error;

    logic [4:0]           lane_shift;
    logic [NB_DATA-1:0]   shifted;
    logic [NB_DATA-1:0]   load_data;
    logic [NB_DATA-1:0]   lane_mask;
    logic [NB_DATA-1:0]   merged;
    logic [NB_ADDR-1:0]   aligned_addr;

    // A request is taken only while idle; computed from state, not o_req_ready.
    assign accept       = i_req_valid && (state_reg == IDLE);
    assign aligned_addr = {addr_reg[NB_ADDR-1:2], 2'b00};

    // Decode the incoming request: access size, legality, alignment and range.
    always_comb begin
        req_size = 3'd1;
        case (i_req_funct3[1:0])
            2'b01:   req_size = 3'd2;
            2'b10:   req_size = 3'd4;
            default: req_size = 3'd1;
        endcase
        if (i_req_we)
            funct3_legal = (i_req_funct3 <= 3'd2);
        else
            funct3_legal = (i_req_funct3 != 3'd3) && (i_req_funct3 != 3'd6) &&
                           (i_req_funct3 != 3'd7);
        misaligned   = ((req_size == 3'd2) && i_req_addr[0]) ||
                       ((req_size == 3'd4) && (i_req_addr[1:0] != 2'b00));
        // One extra bit so addresses near the top of the space cannot wrap.
        req_end      = {1'b0, i_req_addr} + (NB_ADDR+1)'(req_size);
        out_of_range = req_end > (NB_ADDR+1)'(MEM_SIZE);
        req_error    = !funct3_legal || misaligned || out_of_range;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        lane_shift = {addr_reg[1:0], 3'b000};
        shifted    = i_dmem_rd_data >> lane_shift;
        case (funct3_reg)
            3'd0:    load_data = {{(NB_DATA-8){shifted[7]}}, shifted[7:0]};
            3'd1:    load_data = {{(NB_DATA-16){shifted[15]}}, shifted[15:0]};
            3'd4:    load_data = {{(NB_DATA-8){1'b0}}, shifted[7:0]};
            3'd5:    load_data = {{(NB_DATA-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
        lane_mask = (funct3_reg[1:0] == 2'b01) ? NB_DATA'(16'hFFFF) : NB_DATA'(8'hFF);
        merged    = (i_dmem_rd_data & ~(lane_mask << lane_shift)) |
                    ((wdata_reg & lane_mask) << lane_shift);
    end

    // State register; reset aborts any access in progress.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state and memory/handshake outputs.
    always_comb begin
        state_next       = state_reg;
        o_req_ready      = 1'b0;
        o_rsp_valid      = 1'b0;
        o_dmem_address   = '0;
        o_dmem_wr_enable = 1'b0;
        o_dmem_wr_data   = '0;
        case (state_reg)
            IDLE: begin
                o_req_ready = 1'b1;
                if (accept) begin
                    if (req_error)
                        state_next = RESP;
                    else if (i_req_we && (i_req_funct3[1:0] == 2'b10))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                o_dmem_address = aligned_addr;
                state_next     = we_reg ? WRITE : RESP;
            end
            WRITE: begin
                o_dmem_address   = aligned_addr;
                o_dmem_wr_enable = 1'b1;
                o_dmem_wr_data   = word_reg;
                state_next       = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, read-data capture/merge and the registered response.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            we_reg     <= 1'b0;
            funct3_reg <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            word_reg   <= '0;
            rdata_reg  <= '0;
            error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg     <= i_req_we;
                        funct3_reg <= i_req_funct3;
                        addr_reg   <= i_req_addr;
                        wdata_reg  <= i_req_wdata;
                        word_reg   <= i_req_wdata;
                        rdata_reg  <= '0;
                        error_reg  <= req_error;
                    end
                end
                READ: begin
                    if (we_reg)
                        word_reg <= merged;
                    else
                        rdata_reg <= load_data;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rdata_reg <= '0;
                        error_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_rdata = rdata_reg;
    assign o_rsp_error = error_reg;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: byte-array memory model, expected
// responses queued per request and compared when the response arrives.
module tb_lsu_dmem_ctrl;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] dmem_address;
    logic        dmem_wr_enable;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_rd_data;

    logic [7:0]  mem [MEM_SIZE];
    int          wr_pulses = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lsu_dmem_ctrl #(.NB_DATA(32), .NB_ADDR(32), .MEM_SIZE(MEM_SIZE)) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_we        (req_we),
        .i_req_funct3    (req_funct3),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_rsp_valid     (rsp_valid),
        .i_rsp_ready     (rsp_ready),
        .o_rsp_rdata     (rsp_rdata),
        .o_rsp_error     (rsp_error),
        .o_dmem_address  (dmem_address),
        .o_dmem_wr_enable(dmem_wr_enable),
        .o_dmem_wr_data  (dmem_wr_data),
        .i_dmem_rd_data  (dmem_rd_data)
    );

    // Combinational word read, little-endian.
    always_comb begin
        int a;
        a = int'(dmem_address % MEM_SIZE) & ~3;
        dmem_rd_data = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    end

    // Full-word write on the rising edge.
    always @(posedge clk) begin
        if (dmem_wr_enable) begin
            int a;
            a = int'(dmem_address % MEM_SIZE) & ~3;
            mem[a]   <= dmem_wr_data[7:0];
            mem[a+1] <= dmem_wr_data[15:8];
            mem[a+2] <= dmem_wr_data[23:16];
            mem[a+3] <= dmem_wr_data[31:24];
            wr_pulses <= wr_pulses + 1;
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    // Drives one request, measures cycles to response and completes the handshake.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output logic timeout);
        int k;
        timeout = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        rsp_ready = 1'b0;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) timeout = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) timeout = 1'b1;
        rdata = rsp_rdata;
        err   = rsp_error;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn we=%0d f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 we, f3, addr, wdata, rdata, err, lat);
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%08h exp=0", rsp_rdata); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", rsp_error); end
        checks++; if (dmem_wr_enable !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b exp=0", dmem_wr_enable); end
        checks++; if (dmem_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%08h exp=0", dmem_address); end
    endtask

    task automatic test_load();
        logic        we_t   [7] = '{0, 0, 0, 0, 0, 0, 0};
        logic [2:0]  f3_t   [7] = '{2, 0, 4, 1, 5, 2, 4};
        logic [31:0] addr_t [7] = '{32'h10, 32'h10, 32'h10, 32'h12, 32'h10, 32'd1020, 32'd1023};
        logic [31:0] exp_t_ [7] = '{32'h12347F80, 32'hFFFFFF80, 32'h00000080, 32'h00001234,
                                    32'h00007F80, 32'hCAFEF00D, 32'h000000CA};
        logic [31:0] rd; logic er, to; int lat; exp_t e;
        set_word(32'h10, 32'h12347F80);
        set_word(1020, 32'hCAFEF00D);
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{rdata: exp_t_[i], err: 1'b0, lat: 2});
            issue(we_t[i], f3_t[i], addr_t[i], 32'h0, rd, er, lat, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL load_timeout idx=%0d got=timeout exp=response", i); end
            checks++; if (rd !== e.rdata) begin errors++; $display("FAIL load_rdata idx=%0d got=%08h exp=%08h", i, rd, e.rdata); end
            checks++; if (er !== e.err) begin errors++; $display("FAIL load_error idx=%0d got=%0b exp=%0b", i, er, e.err); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL load_latency idx=%0d got=%0d exp=%0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3_t   [4] = '{0, 1, 2, 0};
        logic [31:0] addr_t [4] = '{32'h11, 32'h12, 32'h20, 32'h23};
        logic [31:0] wd_t   [4] = '{32'hAAAAAA55, 32'h0000BEEF, 32'hDEADBEEF, 32'h000000C3};
        logic [31:0] word_t [4] = '{32'h12345580, 32'hBEEF5580, 32'hDEADBEEF, 32'hC3ADBEEF};
        int          lat_t  [4] = '{3, 3, 2, 3};
        logic [31:0] rd; logic er, to; int lat, p0; exp_t e;
        set_word(32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rdata: 32'h0, err: 1'b0, lat: lat_t[i]});
            p0 = wr_pulses;
            issue(1'b1, f3_t[i], addr_t[i], wd_t[i], rd, er, lat, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL store_timeout idx=%0d got=timeout exp=response", i); end
            checks++; if (rd !== e.rdata || er !== e.err) begin errors++; $display("FAIL store_rsp idx=%0d got=%08h/%0b exp=%08h/%0b", i, rd, er, e.rdata, e.err); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL store_latency idx=%0d got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (wr_pulses - p0 != 1) begin errors++; $display("FAIL store_pulses idx=%0d got=%0d exp=1", i, wr_pulses - p0); end
            checks++; if (mem_word(int'(addr_t[i]) & ~3) !== word_t[i]) begin errors++; $display("FAIL store_word idx=%0d got=%08h exp=%08h", i, mem_word(int'(addr_t[i]) & ~3), word_t[i]); end
        end
        sb.push_back('{rdata: 32'hFFFFFFC3, err: 1'b0, lat: 2});
        issue(1'b0, 3'd0, 32'h23, 32'h0, rd, er, lat, to);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata || to) begin errors++; $display("FAIL store_readback got=%08h exp=%08h", rd, e.rdata); end
    endtask

    task automatic test_errors();
        logic        we_t   [8] = '{0, 1, 0, 0, 0, 1, 0, 1};
        logic [2:0]  f3_t   [8] = '{1, 2, 2, 3, 6, 4, 2, 0};
        logic [31:0] addr_t [8] = '{32'h13, 32'h22, 32'd1022, 32'h0, 32'h0, 32'h10, 32'd1024, 32'd1024};
        logic [31:0] rd; logic er, to; int lat, p0; logic [31:0] w10, w20; exp_t e;
        w10 = mem_word(32'h10);
        w20 = mem_word(32'h20);
        p0  = wr_pulses;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
            issue(we_t[i], f3_t[i], addr_t[i], 32'h55555555, rd, er, lat, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL err_timeout idx=%0d got=timeout exp=response", i); end
            checks++; if (er !== e.err) begin errors++; $display("FAIL err_flag idx=%0d got=%0b exp=%0b", i, er, e.err); end
            checks++; if (rd !== e.rdata) begin errors++; $display("FAIL err_rdata idx=%0d got=%08h exp=%08h", i, rd, e.rdata); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL err_latency idx=%0d got=%0d exp=%0d", i, lat, e.lat); end
        end
        checks++; if (wr_pulses != p0) begin errors++; $display("FAIL err_no_write got=%0d exp=0", wr_pulses - p0); end
        checks++; if (mem_word(32'h10) !== w10 || mem_word(32'h20) !== w20) begin errors++; $display("FAIL err_mem got=%08h,%08h exp=%08h,%08h", mem_word(32'h10), mem_word(32'h20), w10, w20); end
    endtask

    task automatic test_stall();
        logic [31:0] held; int lat; logic [31:0] rd; logic er, to; exp_t e;
        set_word(32'h40, 32'h89ABCDEF);
        sb.push_back('{rdata: 32'h89ABCDEF, err: 1'b0, lat: 2});
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        // Keep a second request pending through the stall; it must not be taken.
        req_addr = 32'h10;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL stall_latency got=%0d exp=%0d", lat, e.lat); end
        held = rsp_rdata;
        checks++; if (held !== e.rdata) begin errors++; $display("FAIL stall_rdata got=%08h exp=%08h", held, e.rdata); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0 || dmem_address !== 32'h0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got valid=%0b rdata=%08h ready=%0b addr=%08h exp 1/%08h/0/0",
                         c, rsp_valid, rsp_rdata, req_ready, dmem_address, e.rdata);
            end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got ready=%0b valid=%0b exp 1/0", req_ready, rsp_valid); end
        // The pending request is accepted now: LW 0x10.
        @(posedge clk); #1; req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (rsp_rdata !== mem_word(32'h10) || lat != 2) begin errors++; $display("FAIL stall_next got=%08h lat=%0d exp=%08h lat=2", rsp_rdata, lat, mem_word(32'h10)); end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        $display("txn stalled LW 0x40 then LW 0x10 accepted after handshake");
        sb.push_back('{rdata: 32'h89ABCDEF, err: 1'b0, lat: 2});
        issue(1'b0, 3'd2, 32'h40, 32'h0, rd, er, lat, to);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata || lat != e.lat || to) begin errors++; $display("FAIL stall_after got=%08h lat=%0d exp=%08h lat=%0d", rd, lat, e.rdata, e.lat); end
    endtask

    task automatic test_reset_mid_op();
        int p0;
        set_word(32'h30, 32'h11223344);
        p0 = wr_pulses;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h32; req_wdata = 32'h00005555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (dmem_address !== 32'h30) begin errors++; $display("FAIL rst_in_read got addr=%08h exp=00000030", dmem_address); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dmem_wr_enable !== 1'b0 || dmem_address !== 32'h0 ||
            rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got ready=%0b valid=%0b wr=%0b addr=%08h rdata=%08h err=%0b exp 1/0/0/0/0/0",
                     req_ready, rsp_valid, dmem_wr_enable, dmem_address, rsp_rdata, rsp_error);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_pulses != p0) begin errors++; $display("FAIL rst_no_write got=%0d exp=0", wr_pulses - p0); end
        checks++; if (mem_word(32'h30) !== 32'h11223344) begin errors++; $display("FAIL rst_mem got=%08h exp=11223344", mem_word(32'h30)); end
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_release got ready=%0b valid=%0b exp 1/0", req_ready, rsp_valid); end
        $display("txn SH 0x32 aborted by reset in READ");
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_load();
        test_store();
        test_errors();
        test_stall();
        test_reset_mid_op();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends with a summary.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
